// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid buffer (main + skid), so ex_ready
// comes straight from a flop while streaming at full rate; also counts MEM stall cycles.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_instr,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_st_val,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [2:0]        ex_ctrl,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_pc,
    output logic [DATA_W-1:0] mem_instr,
    output logic [DATA_W-1:0] mem_alu_res,
    output logic [DATA_W-1:0] mem_st_val,
    output logic [REG_W-1:0]  mem_dest,
    output logic [2:0]        mem_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW = 4 * DATA_W + REG_W + 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_mem_valid;
    logic              r_skid_valid;
    logic [PW-1:0]     r_main;
    logic [PW-1:0]     r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_accept;
    logic              w_emit;
    logic [PW-1:0]     w_in;
    logic [2:0]        w_main_ctrl;

    assign w_accept = ex_valid && !r_skid_valid;
    assign w_emit   = r_mem_valid && mem_ready;
    assign w_in     = {ex_pc, ex_instr, ex_alu_res, ex_st_val, ex_dest, ex_ctrl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_mem_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
            r_stall_cnt  <= '0;
        end else begin
            // Stall counter survives flush; only reset clears it.
            if (r_mem_valid && !mem_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            if (flush) begin
                r_state      <= S_EMPTY;
                r_mem_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_accept) begin
                            r_main      <= w_in;
                            r_mem_valid <= 1'b1;
                            r_state     <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_accept && w_emit) begin
                            r_main <= w_in;
                        end else if (w_accept) begin
                            r_skid       <= w_in;
                            r_skid_valid <= 1'b1;
                            r_state      <= S_FULL;
                        end else if (w_emit) begin
                            r_mem_valid <= 1'b0;
                            r_state     <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (w_emit) begin
                            r_main       <= r_skid;
                            r_skid_valid <= 1'b0;
                            r_state      <= S_ONE;
                        end
                    end
                    default: begin
                        r_state      <= S_EMPTY;
                        r_mem_valid  <= 1'b0;
                        r_skid_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ex_ready  = !r_skid_valid;
    assign mem_valid = r_mem_valid;
    assign stall_cnt = r_stall_cnt;
    assign {mem_pc, mem_instr, mem_alu_res, mem_st_val, mem_dest, w_main_ctrl} = r_main;
    // Stale payload may linger after a flush, so control bits are masked by valid.
    assign mem_ctrl  = r_mem_valid ? w_main_ctrl : 3'b000;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Bench for exe_mem_skid_reg: directed scenarios plus random traffic, compared each
// cycle against a queue model of at most two in-flight payloads.
module tb_exe_mem_skid_reg;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int PW = 4 * DW + RW + 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_pc, ex_instr, ex_alu_res, ex_st_val;
    logic [RW-1:0] ex_dest;
    logic [2:0]    ex_ctrl;
    logic          mem_valid;
    logic          mem_ready;
    logic [DW-1:0] mem_pc, mem_instr, mem_alu_res, mem_st_val;
    logic [RW-1:0] mem_dest;
    logic [2:0]    mem_ctrl;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] q[$];
    int            exp_cnt = 0;

    exe_mem_skid_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_alu_res(ex_alu_res),
        .ex_st_val(ex_st_val), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_alu_res(mem_alu_res),
        .mem_st_val(mem_st_val), .mem_dest(mem_dest), .mem_ctrl(mem_ctrl),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [PW-1:0] dut_pl;
        logic [PW-1:0] e;
        dut_pl = {mem_pc, mem_instr, mem_alu_res, mem_st_val, mem_dest, mem_ctrl};
        chk("mem_valid", PW'(mem_valid), PW'(q.size() > 0));
        chk("ex_ready", PW'(ex_ready), PW'(q.size() < 2));
        chk("stall_cnt", PW'(stall_cnt), PW'(exp_cnt));
        if (q.size() > 0) begin
            e = q[0];
            chk("payload", dut_pl, e);
        end else begin
            chk("mem_ctrl_idle", PW'(mem_ctrl), '0);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc);
        ex_valid   = v;
        ex_pc      = pc;
        ex_instr   = $urandom;
        ex_alu_res = $urandom;
        ex_st_val  = $urandom;
        ex_dest    = RW'($urandom);
        ex_ctrl    = 3'($urandom);
    endtask

    // One clock: apply the queue model to the values sampled at the edge, then check.
    task automatic tick();
        bit m_emit, m_acc;
        @(posedge clk);
        m_emit = (q.size() > 0) && mem_ready;
        m_acc  = ex_valid && (q.size() < 2);
        if (q.size() > 0 && !mem_ready && exp_cnt < CNT_MAX) exp_cnt++;
        if (flush) begin
            q.delete();
        end else begin
            if (m_emit) void'(q.pop_front());
            if (m_acc) q.push_back({ex_pc, ex_instr, ex_alu_res, ex_st_val, ex_dest, ex_ctrl});
        end
        #1 check_all();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        drive(1'b1, 32'hdead_beef);
        ex_ctrl = 3'b111;

        // Reset held for 3 cycles with live inputs; nothing may leak through.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0);
        #1;
        chk("rst_mem_valid", PW'(mem_valid), '0);
        chk("rst_ex_ready", PW'(ex_ready), PW'(1));
        chk("rst_stall_cnt", PW'(stall_cnt), '0);
        chk("rst_mem_ctrl", PW'(mem_ctrl), '0);

        // Streaming: each pc appears one cycle later, no bubbles.
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i * 4));
            tick();
            chk("stream_pc", PW'(mem_pc), PW'(i * 4));
            chk("stream_ready", PW'(ex_ready), PW'(1));
        end
        drive(1'b0, '0);
        tick();

        // Back-pressure: 0x10 in main, 0x14 in skid, 0x18 held by EXE.
        mem_ready = 1'b0;
        drive(1'b1, 32'h10); tick();
        drive(1'b1, 32'h14); tick();
        chk("bp_full_ready", PW'(ex_ready), '0);
        drive(1'b1, 32'h18); tick(); tick();
        chk("bp_hold_pc", PW'(mem_pc), PW'(32'h10));
        chk("bp_stall_cnt", PW'(stall_cnt), PW'(3));
        mem_ready = 1'b1;
        tick();
        chk("bp_order_2", PW'(mem_pc), PW'(32'h14));
        tick();
        chk("bp_order_3", PW'(mem_pc), PW'(32'h18));
        drive(1'b0, '0);
        tick();

        // Flush while FULL with a same-cycle valid payload.
        mem_ready = 1'b0;
        drive(1'b1, 32'h20); tick();
        drive(1'b1, 32'h24); tick();
        flush = 1'b1;
        drive(1'b1, 32'h28);
        tick();
        flush = 1'b0;
        chk("flush_valid", PW'(mem_valid), '0);
        chk("flush_ready", PW'(ex_ready), PW'(1));
        chk("flush_ctrl", PW'(mem_ctrl), '0);
        drive(1'b0, '0);
        mem_ready = 1'b1;
        tick(); tick();

        // Saturation of the stall counter.
        mem_ready = 1'b0;
        drive(1'b1, 32'h30); tick();
        drive(1'b0, '0);
        repeat (20) tick();
        chk("sat_cnt", PW'(stall_cnt), PW'(CNT_MAX));

        // Async reset in the middle of a cycle while FULL.
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0;
        drive(1'b1, 32'h40); tick();
        drive(1'b1, 32'h44); tick();
        chk("pre_arst_full", PW'(ex_ready), '0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", PW'(mem_valid), '0);
        chk("arst_ready", PW'(ex_ready), PW'(1));
        chk("arst_cnt", PW'(stall_cnt), '0);
        chk("arst_ctrl", PW'(mem_ctrl), '0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom);
            mem_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
